// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI mode-0 initiator.
//   BYTE_W      - frame width in bits
//   CLK_DIV_DEF - default SCLK half-period in clk cycles
//   state_e     - byte engine states
package spi_pkg;
    localparam int BYTE_W = 8;
    localparam int CLK_DIV_DEF = 4;
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_e;
endpackage

// File: rtl/spi_div_counter.sv
// spi_div_counter: reloadable down-counter giving a one-cycle tick DIV cycles after each restart.
//   clk_i     - system clock
//   rst_i     - asynchronous active-high reset
//   restart_i - reload the count (asserted on every state entry)
//   tick_o    - high in the last cycle of the DIV-cycle interval
module spi_div_counter #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);
    logic [7:0] cnt_q, cnt_d;

    // Loading DIV-1 makes the tick fall in the cycle before the DIV-th edge,
    // so the state change lands exactly DIV edges after entry.
    always_comb cnt_d = restart_i ? 8'(DIV - 1) : (cnt_q != 8'd0 ? cnt_q - 8'd1 : 8'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = cnt_q == 8'd0;
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first, 8-bit frames).
//   clk_i, rst_i   - system clock, asynchronous active-high reset
//   start_i        - one-cycle byte request, accepted only when idle
//   tx_data_i      - byte to send, latched on an accepted start
//   hold_ss_i      - keep SS low after this byte
//   ss_release_i   - deassert a held SS without sending a byte
//   rx_data_o      - last received byte, updated with done_o
//   done_o         - one-cycle end-of-byte pulse
//   busy_o         - engine cannot accept a start
//   sclk_o, ss_o, mosi_o, miso_i - SPI pins
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              hold_ss_i,
    input  logic              ss_release_i,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              ss_o,
    output logic              mosi_o,
    input  logic              miso_i
);
    state_e            state_q, state_d;
    logic [BYTE_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              hold_q, hold_d, sclk_q, sclk_d, ss_q, ss_d, done_q, done_d;
    logic [1:0]        miso_sync_q;
    logic              tick;

    // Every transition out of a non-idle state happens on a tick, so a state
    // change is exactly the moment the half-period timer must restart.
    spi_div_counter #(.DIV(CLK_DIV)) u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .restart_i(state_d != state_q),
        .tick_o   (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tx_sh_d   = tx_data_i;
                    hold_d    = hold_ss_i;
                    ss_d      = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = SETUP;
                end else if (ss_release_i && !ss_q) begin
                    ss_d    = 1'b1;
                    state_d = GAP;
                end
            end
            SETUP, LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[BYTE_W-2:0], miso_sync_q[1]};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 3'(BYTE_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        tx_sh_d   = {tx_sh_q[BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = LOW;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    ss_d      = !hold_q;
                    state_d   = hold_q ? IDLE : GAP;
                end
            end
            GAP:     state_d = tick ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= 3'd0;
            hold_q      <= 1'b0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            done_q      <= 1'b0;
            miso_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            done_q      <= done_d;
            miso_sync_q <= {miso_sync_q[0], miso_i};
        end
    end

    assign rx_data_o = rx_data_q;
    assign done_o    = done_q;
    assign busy_o    = state_q != IDLE;
    assign sclk_o    = sclk_q;
    assign ss_o      = ss_q;
    // MOSI is the MSB of the transmit shifter, so it only moves on the shift at a falling SCLK.
    assign mosi_o    = tx_sh_q[BYTE_W-1];
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed checks of spi_master against a byte-level peripheral model.
module tb_spi_master;
    localparam int D = 4;

    logic       clk = 1'b0, rst_i = 1'b1;
    logic       start_i = 1'b0, hold_ss_i = 1'b0, ss_release_i = 1'b0, miso_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic [7:0] rx_data_o;
    logic       done_o, busy_o, sclk_o, ss_o, mosi_o;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    spi_master #(.CLK_DIV(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .tx_data_i   (tx_data_i),
        .hold_ss_i   (hold_ss_i),
        .ss_release_i(ss_release_i),
        .rx_data_o   (rx_data_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .sclk_o      (sclk_o),
        .ss_o        (ss_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Peripheral model: presents a new byte whenever the master begins a byte
    // (busy rises with SS low) and advances one bit after every SCLK fall.
    // Also records the edge index and MOSI value at every SCLK rise.
    logic [7:0] resp_q[$];
    int         rise_t[$];
    logic       rise_b[$];
    logic [7:0] cur = 8'h00;
    int         idx = 0;
    logic       sclk_p = 1'b0, busy_p = 1'b0;

    always @(negedge clk) begin
        if (sclk_o && !sclk_p) begin
            rise_t.push_back(cyc);
            rise_b.push_back(mosi_o);
        end
        if (!sclk_o && sclk_p) begin
            idx = idx + 1;
            if (idx < 8) miso_i = cur[7-idx];
        end
        if (busy_o && !busy_p && !ss_o) begin
            cur = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
            idx = 0;
            miso_i = cur[7];
        end
        sclk_p = sclk_o;
        busy_p = busy_o;
    end

    // One byte transfer from a negedge; poke re-pulses start at edge 10.
    task automatic xfer(input logic [7:0] tx, input logic hold, input logic [7:0] resp,
                        input logic rel, input logic poke);
        int e0, n, t_done, t_ss, t_busy, n_done, bad_t;
        logic [7:0] mo;
        resp_q.push_back(resp);
        rise_t.delete();
        rise_b.delete();
        start_i = 1'b1; tx_data_i = tx; hold_ss_i = hold; ss_release_i = rel;
        e0 = cyc + 1;
        @(negedge clk);
        start_i = 1'b0; ss_release_i = 1'b0; tx_data_i = 8'h00; hold_ss_i = 1'b0;
        check("ss_low_at_start", ss_o, 0);
        check("busy_at_start", busy_o, 1);
        t_done = -1; t_ss = -1; t_busy = -1; n_done = 0;
        for (int i = 0; i < 30 * D; i++) begin
            if (poke && cyc - e0 == 9) begin
                start_i = 1'b1; tx_data_i = 8'hFF; hold_ss_i = 1'b0;
            end
            @(negedge clk);
            start_i = 1'b0;
            n = cyc - e0;
            if (done_o) begin
                n_done++;
                if (t_done < 0) begin t_done = n; check("rx_data", rx_data_o, resp); end
            end
            if (ss_o && t_ss < 0) t_ss = n;
            if (!busy_o && t_busy < 0) t_busy = n;
        end
        mo = 8'h00;
        bad_t = 0;
        for (int k = 0; k < rise_b.size() && k < 8; k++) mo[7-k] = rise_b[k];
        for (int k = 0; k < rise_t.size(); k++) if (rise_t[k] - e0 != D * (2 * k + 1)) bad_t++;
        check("rise_count", rise_t.size(), 8);
        check("mosi_byte", mo, tx);
        check("rise_timing", bad_t, 0);
        check("done_edge", t_done, 17 * D);
        check("done_count", n_done, 1);
        check("ss_rise_edge", t_ss, hold ? -1 : 17 * D);
        check("busy_fall_edge", t_busy, hold ? 17 * D : 18 * D);
    endtask

    initial begin
        int busy_n, n_done;
        logic prev_hold;
        repeat (3) @(negedge clk);
        check("rst_ss", ss_o, 1);
        check("rst_sclk", sclk_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rx", rx_data_o, 8'h00);
        rst_i = 1'b0;
        @(negedge clk);

        xfer(8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0);
        xfer(8'h12, 1'b1, 8'h81, 1'b0, 1'b0);
        xfer(8'h34, 1'b0, 8'h7E, 1'b0, 1'b0);
        xfer(8'h5A, 1'b0, 8'hC3, 1'b0, 1'b1);

        // Reset in the middle of a byte
        resp_q.push_back(8'h66);
        start_i = 1'b1; tx_data_i = 8'hA5; hold_ss_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (28) @(negedge clk);
        @(posedge clk);
        #1 rst_i = 1'b1;
        #1;
        check("midrst_ss", ss_o, 1);
        check("midrst_sclk", sclk_o, 0);
        check("midrst_mosi", mosi_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_rx", rx_data_o, 8'h00);
        @(negedge clk);
        rst_i = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25 * D; i++) begin
            @(negedge clk);
            if (done_o) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_rx_after", rx_data_o, 8'h00);

        // Release a held SS without a byte
        xfer(8'h99, 1'b1, 8'h42, 1'b0, 1'b0);
        rise_t.delete();
        ss_release_i = 1'b1;
        @(negedge clk);
        ss_release_i = 1'b0;
        check("release_ss", ss_o, 1);
        busy_n = 0;
        for (int i = 0; i < 3 * D; i++) begin
            if (busy_o) busy_n++;
            @(negedge clk);
        end
        check("release_busy_cycles", busy_n, D);
        check("release_no_sclk", rise_t.size(), 0);

        // Randomized bytes, holds and start+release collisions
        prev_hold = 1'b0;
        for (int t = 0; t < 20; t++) begin
            logic [7:0] tx, rs;
            logic h, rl;
            tx = 8'($urandom);
            rs = 8'($urandom);
            h  = 1'($urandom_range(0, 1));
            rl = prev_hold & 1'($urandom_range(0, 1));
            xfer(tx, h, rs, rl, 1'b0);
            prev_hold = h;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
